// File: rtl/pll_lock_reset_ctrl_pkg.sv
// Shared constants and the reset-sequencer state encoding for the WiMax PHY
// reset controller.
package pll_lock_reset_ctrl_pkg;

    localparam int PLL_SYNC_STAGES        = 2;
    localparam int PLL_LOCK_STABLE_CYCLES = 16;
    localparam int PHY_STAGE_GAP          = 4;
    localparam int NUM_PHY_STAGES         = 4;
    localparam int PLL_LOSS_CNT_W         = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_if.sv
// Lock/request inputs and per-stage reset/status outputs of the PHY reset
// controller.
interface pll_lock_reset_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int LOSS_CNT_W = 8
);
    logic                  pll_locked;
    logic                  sw_reset_req;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  phy_ready;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic                  locked_sync;

    modport master (
        output pll_locked,
        output sw_reset_req,
        input  stage_rst,
        input  phy_ready,
        input  lock_loss_cnt,
        input  locked_sync
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output stage_rst,
        output phy_ready,
        output lock_loss_cnt,
        output locked_sync
    );
endinterface

// File: rtl/pll_lock_reset_ctrl_cdc_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal; clears to 0
// on reset.
module cdc_bit_sync
    import pll_lock_reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = PLL_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// Qualifies PLL lock and releases the PHY stage resets one by one, re-asserting
// them all on lock loss or software request.
module pll_lock_reset_ctrl
    import pll_lock_reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES        = PLL_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = PLL_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP_CYCLES   = PHY_STAGE_GAP,
    parameter int NUM_STAGES         = NUM_PHY_STAGES,
    parameter int LOSS_CNT_W         = PLL_LOSS_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_lock_reset_ctrl_if.slave  bus
);

    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int GAP_W    = cnt_width(STAGE_GAP_CYCLES);
    localparam int IDX_W    = cnt_width(NUM_STAGES);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    rst_seq_state_t state_reg, state_next;
    logic [STABLE_W-1:0]   stable_cnt_reg, stable_cnt_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [IDX_W-1:0]      stage_idx_reg, stage_idx_next;
    logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic                  phy_ready_reg, phy_ready_next;
    logic [LOSS_CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
    logic                  locked_sync_reg;
    logic                  sync_out;

    cdc_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (sync_out)
    );

    // Extra register stage so the FSM and the status port see the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_sync_reg <= 1'b0;
        end else begin
            locked_sync_reg <= sync_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= WAIT_LOCK;
            stable_cnt_reg <= '0;
            gap_cnt_reg    <= '0;
            stage_idx_reg  <= '0;
            stage_rst_reg  <= '1;
            phy_ready_reg  <= 1'b0;
            loss_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            stable_cnt_reg <= stable_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            stage_idx_reg  <= stage_idx_next;
            stage_rst_reg  <= stage_rst_next;
            phy_ready_reg  <= phy_ready_next;
            loss_cnt_reg   <= loss_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = stable_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        stage_idx_next  = stage_idx_reg;
        stage_rst_next  = stage_rst_reg;
        phy_ready_next  = phy_ready_reg;
        loss_cnt_next   = loss_cnt_reg;

        unique case (state_reg)
            WAIT_LOCK: begin
                stage_rst_next = '1;
                phy_ready_next = 1'b0;
                if (locked_sync_reg) begin
                    state_next      = STABLE;
                    stable_cnt_next = '0;
                end
            end

            STABLE: begin
                if (!locked_sync_reg || bus.sw_reset_req) begin
                    state_next = WAIT_LOCK;
                end else if (stable_cnt_reg == STABLE_LAST) begin
                    state_next     = RELEASE;
                    gap_cnt_next   = '0;
                    stage_idx_next = '0;
                end else begin
                    stable_cnt_next = stable_cnt_reg + STABLE_W'(1);
                end
            end

            RELEASE, RUN: begin
                // Lock loss takes priority so a coincident request still counts.
                if (!locked_sync_reg || bus.sw_reset_req) begin
                    state_next     = WAIT_LOCK;
                    stage_rst_next = '1;
                    phy_ready_next = 1'b0;
                    if (!locked_sync_reg && (loss_cnt_reg != '1)) begin
                        loss_cnt_next = loss_cnt_reg + LOSS_CNT_W'(1);
                    end
                end else if (state_reg == RELEASE) begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_next   = '0;
                        stage_rst_next = stage_rst_reg & ~(NUM_STAGES'(1) << stage_idx_reg);
                        if (stage_idx_reg == IDX_LAST) begin
                            state_next     = RUN;
                            phy_ready_next = 1'b1;
                        end else begin
                            stage_idx_next = stage_idx_reg + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    assign bus.stage_rst     = stage_rst_reg;
    assign bus.phy_ready     = phy_ready_reg;
    assign bus.lock_loss_cnt = loss_cnt_reg;
    assign bus.locked_sync   = locked_sync_reg;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed bench for pll_lock_reset_ctrl: release timeline, lock loss, software
// re-sequence, asynchronous reset and loss-counter saturation.
module tb_pll_lock_reset_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pll_lock_reset_ctrl_if #(.NUM_STAGES(4), .LOSS_CNT_W(8)) bus ();

    pll_lock_reset_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected stage_rst n edges after the edge that first samples pll_locked=1
    // (default parameters, clean lock from WAIT_LOCK).
    function automatic logic [3:0] exp_rst(input int n);
        if (n < 23) return 4'b1111;
        if (n < 27) return 4'b1110;
        if (n < 31) return 4'b1100;
        if (n < 35) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic exp_ready(input int n);
        return (n >= 35);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        bus.sw_reset_req = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.stage_rst !== 4'b1111 || bus.phy_ready !== 1'b0 ||
            bus.lock_loss_cnt !== 8'd0 || bus.locked_sync !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: stage_rst=%b phy_ready=%b cnt=%0d locked_sync=%b, want 1111/0/0/0",
                     bus.stage_rst, bus.phy_ready, bus.lock_loss_cnt, bus.locked_sync);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_sequence();
        rst = 1'b0;
        bus.pll_locked = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            tick();
            tests_run++;
            if (bus.stage_rst !== exp_rst(n) || bus.phy_ready !== exp_ready(n) ||
                bus.locked_sync !== (n >= 2)) begin
                tests_failed++;
                $display("FAIL basic_seq edge %0d: stage_rst=%b phy_ready=%b locked_sync=%b, want %b/%b/%b",
                         n, bus.stage_rst, bus.phy_ready, bus.locked_sync, exp_rst(n), exp_ready(n), n >= 2);
            end
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL basic_seq_cnt: lock_loss_cnt=%0d, want 0", bus.lock_loss_cnt);
        end
        $display("[TB] test_basic_sequence done");
    endtask

    task automatic test_lock_loss();
        bus.pll_locked = 1'b0;
        for (int n = 0; n <= 3; n++) begin
            tick();
            tests_run++;
            if (bus.stage_rst !== ((n < 3) ? 4'b0000 : 4'b1111) || bus.phy_ready !== (n < 3)) begin
                tests_failed++;
                $display("FAIL lock_loss_latency edge %0d: stage_rst=%b phy_ready=%b, want %b/%b",
                         n, bus.stage_rst, bus.phy_ready, (n < 3) ? 4'b0000 : 4'b1111, n < 3);
            end
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL lock_loss_cnt: lock_loss_cnt=%0d, want 1", bus.lock_loss_cnt);
        end
        bus.pll_locked = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            tick();
            tests_run++;
            if (bus.stage_rst !== exp_rst(n) || bus.phy_ready !== exp_ready(n)) begin
                tests_failed++;
                $display("FAIL relock_seq edge %0d: stage_rst=%b phy_ready=%b, want %b/%b",
                         n, bus.stage_rst, bus.phy_ready, exp_rst(n), exp_ready(n));
            end
        end
        $display("[TB] test_lock_loss done");
    endtask

    task automatic test_sw_reset();
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        tests_run++;
        if (bus.stage_rst !== 4'b1111 || bus.phy_ready !== 1'b0 || bus.lock_loss_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL sw_reset_assert: stage_rst=%b phy_ready=%b cnt=%0d, want 1111/0/1",
                     bus.stage_rst, bus.phy_ready, bus.lock_loss_cnt);
        end
        // Lock is still held, so STABLE starts one edge after the request.
        for (int n = 1; n <= 40; n++) begin
            tick();
            tests_run++;
            if (bus.stage_rst !== exp_rst(n + 2) || bus.phy_ready !== exp_ready(n + 2)) begin
                tests_failed++;
                $display("FAIL sw_reseq edge %0d: stage_rst=%b phy_ready=%b, want %b/%b",
                         n, bus.stage_rst, bus.phy_ready, exp_rst(n + 2), exp_ready(n + 2));
            end
        end
        // Request lands on the same edge that first sees the lost lock.
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        tests_run++;
        if (bus.stage_rst !== 4'b1111 || bus.lock_loss_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL coincident_loss: stage_rst=%b cnt=%0d, want 1111/2",
                     bus.stage_rst, bus.lock_loss_cnt);
        end
        $display("[TB] test_sw_reset done");
    endtask

    task automatic test_async_reset();
        bus.pll_locked = 1'b1;
        for (int n = 0; n <= 28; n++) tick();
        tests_run++;
        if (bus.stage_rst !== 4'b1100) begin
            tests_failed++;
            $display("FAIL mid_release_pre: stage_rst=%b, want 1100", bus.stage_rst);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.stage_rst !== 4'b1111 || bus.phy_ready !== 1'b0 ||
            bus.lock_loss_cnt !== 8'd0 || bus.locked_sync !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: stage_rst=%b phy_ready=%b cnt=%0d locked_sync=%b, want 1111/0/0/0",
                     bus.stage_rst, bus.phy_ready, bus.lock_loss_cnt, bus.locked_sync);
        end
        tick();
        rst = 1'b0;
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_stable_glitch();
        logic [3:0] want_rst;
        logic       want_rdy;
        for (int n = 0; n <= 53; n++) begin
            tick();
            if (n == 9)  bus.pll_locked = 1'b0;
            if (n == 12) bus.pll_locked = 1'b1;
            want_rst = (n < 13) ? 4'b1111 : exp_rst(n - 13);
            want_rdy = (n < 13) ? 1'b0 : exp_ready(n - 13);
            tests_run++;
            if (bus.stage_rst !== want_rst || bus.phy_ready !== want_rdy) begin
                tests_failed++;
                $display("FAIL stable_glitch edge %0d: stage_rst=%b phy_ready=%b, want %b/%b",
                         n, bus.stage_rst, bus.phy_ready, want_rst, want_rdy);
            end
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL stable_glitch_cnt: lock_loss_cnt=%0d, want 0", bus.lock_loss_cnt);
        end
        $display("[TB] test_stable_glitch done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 255; i++) begin
            bus.pll_locked = 1'b0;
            repeat (4) tick();
            bus.pll_locked = 1'b1;
            repeat (21) tick();
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_255: lock_loss_cnt=%0d, want 255", bus.lock_loss_cnt);
        end
        bus.pll_locked = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd255 || bus.stage_rst !== 4'b1111) begin
            tests_failed++;
            $display("FAIL sat_hold: lock_loss_cnt=%0d stage_rst=%b, want 255/1111",
                     bus.lock_loss_cnt, bus.stage_rst);
        end
        $display("[TB] test_saturation done");
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_lock_loss();
        test_sw_reset();
        test_async_reset();
        test_stable_glitch();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
